pll_lock_sequencer: RTL and testbench

//  Sequences the 40 MHz-referenced PLL that produces clk200m/clk400m: pulses PLL RST, waits for LOCKED,

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// The state encoding and the saturating loss-counter helper live here.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStabilize,
    StRun,
    StFail
  } pll_state_e;

  localparam int unsigned DefRstPulseCyc   = 16;
  localparam int unsigned DefLockTimeoutCyc = 4000;
  localparam int unsigned DefStableCyc     = 256;
  localparam int unsigned DefMaxRetry      = 3;
  localparam int unsigned DefCntW          = 16;

  localparam int unsigned RetryCntW = 2;
  localparam int unsigned LossCntW  = 8;

  function automatic logic [LossCntW-1:0] sat_inc_loss(input logic [LossCntW-1:0] v);
    return (v == '1) ? v : v + LossCntW'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both stages reset to 0 so a stale LOCKED is never seen after reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Pulses PLL reset, qualifies LOCKED stability and releases the fast-domain reset.
// Retries on lock timeout, re-sequences on lock loss or relock_req, flags permanent failure.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = DefRstPulseCyc,
  parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
  parameter int unsigned STABLE_CYC       = DefStableCyc,
  parameter int unsigned MAX_RETRY        = DefMaxRetry,
  parameter int unsigned CNT_W            = DefCntW
) (
  input  logic                 clk40m,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 relock_req,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 clk_ready,
  output logic                 lock_fail,
  output logic [RetryCntW-1:0] retry_cnt,
  output logic [LossCntW-1:0]  loss_cnt
);

  localparam logic [CNT_W-1:0]     RstLast     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]     TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]     StableLast  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RetryCntW-1:0] MaxRetry    = RetryCntW'(MAX_RETRY);

  pll_state_e           state_q;
  logic [CNT_W-1:0]     timer_q;
  logic [CNT_W-1:0]     timer_inc;
  logic                 pll_rst_q;
  logic                 sys_rst_q;
  logic                 clk_ready_q;
  logic                 lock_fail_q;
  logic [RetryCntW-1:0] retry_q;
  logic [LossCntW-1:0]  loss_q;
  logic                 locked_s;

  sync_2ff u_sync_locked (
    .clk_i (clk40m),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Saturating increment keeps the shared timer from ever wrapping.
  always_comb begin
    timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
  end

  always_ff @(posedge clk40m) begin
    if (rst) begin
      state_q     <= StResetPll;
      timer_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      lock_fail_q <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else if (relock_req) begin
      state_q     <= StResetPll;
      timer_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      lock_fail_q <= 1'b0;
      retry_q     <= '0;
      // A loss that coincides with the request is still recorded.
      if (state_q == StRun && !locked_s) begin
        loss_q <= sat_inc_loss(loss_q);
      end
    end else begin
      case (state_q)
        StResetPll: begin
          if (timer_q == RstLast) begin
            state_q   <= StWaitLock;
            timer_q   <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer_q <= timer_inc;
          end
        end

        StWaitLock: begin
          if (locked_s) begin
            state_q <= StStabilize;
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            timer_q <= '0;
            if (retry_q == MaxRetry) begin
              state_q     <= StFail;
              lock_fail_q <= 1'b1;
            end else begin
              state_q   <= StResetPll;
              pll_rst_q <= 1'b1;
              retry_q   <= retry_q + RetryCntW'(1);
            end
          end else begin
            timer_q <= timer_inc;
          end
        end

        StStabilize: begin
          if (!locked_s) begin
            state_q <= StWaitLock;
            timer_q <= '0;
          end else if (timer_q == StableLast) begin
            state_q     <= StRun;
            timer_q     <= '0;
            clk_ready_q <= 1'b1;
            sys_rst_q   <= 1'b0;
          end else begin
            timer_q <= timer_inc;
          end
        end

        StRun: begin
          if (!locked_s) begin
            state_q     <= StResetPll;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            retry_q     <= '0;
            loss_q      <= sat_inc_loss(loss_q);
          end
        end

        StFail: begin
          pll_rst_q   <= 1'b0;
          sys_rst_q   <= 1'b1;
          clk_ready_q <= 1'b0;
          lock_fail_q <= 1'b1;
        end

        default: begin
          state_q     <= StResetPll;
          timer_q     <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_q   <= 1'b1;
          clk_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign clk_ready = clk_ready_q;
  assign lock_fail = lock_fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with shortened timing parameters.
// Expected latencies and event times are queued when stimulus is applied and scored on observation.
module tb_pll_lock_sequencer;

  localparam int RstPulse = 4;
  localparam int Timeout  = 20;
  localparam int Stable   = 8;
  localparam int MaxRetry = 2;
  localparam int LockLat  = 2 + Stable + 1;

  logic       clk40m     = 1'b0;
  logic       rst        = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       clk_ready;
  logic       lock_fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (RstPulse),
    .LOCK_TIMEOUT_CYC (Timeout),
    .STABLE_CYC       (Stable),
    .MAX_RETRY        (MaxRetry),
    .CNT_W            (16)
  ) dut (
    .clk40m     (clk40m),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .clk_ready  (clk_ready),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk40m = ~clk40m;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic score(input int obs);
    exp_t e;
    check_eq("sb_pending", (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk40m);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return pll_rst;
      1:       return clk_ready;
      default: return lock_fail;
    endcase
  endfunction

  // Ticks until the selected output reaches level; n = -1 if the bound expires.
  task automatic count_until(input int which, input logic level, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (sig_of(which) === level) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic assert_reset(input string pfx);
    rst        = 1'b1;
    relock_req = 1'b0;
    tick();
    check_eq({pfx, "_pll_rst"},   int'(pll_rst),   1);
    check_eq({pfx, "_sys_rst"},   int'(sys_rst),   1);
    check_eq({pfx, "_clk_ready"}, int'(clk_ready), 0);
    check_eq({pfx, "_lock_fail"}, int'(lock_fail), 0);
    check_eq({pfx, "_retry_cnt"}, int'(retry_cnt), 0);
    check_eq({pfx, "_loss_cnt"},  int'(loss_cnt),  0);
    rst = 1'b0;
  endtask

  always @(negedge clk40m) begin
    if (mon_en) check_eq("sys_rst_vs_clk_ready", int'(sys_rst), int'(!clk_ready));
  end

  initial begin
    int   n;
    int   loss_model;
    int   bad;
    int   fail_at;
    logic prev;

    // 1: first lock after reset
    pll_locked = 1'b0;
    assert_reset("t1_reset");
    mon_en = 1'b1;
    expect_val("t1_pll_rst_width", RstPulse);
    count_until(0, 1'b0, 50, n);
    score(n);
    repeat (10) tick();
    pll_locked = 1'b1;
    expect_val("t1_lock_latency", LockLat);
    count_until(1, 1'b1, 100, n);
    score(n);
    check_eq("t1_sys_rst", int'(sys_rst), 0);

    // 3: one-cycle glitch while stabilising at count 5
    pll_locked = 1'b0;
    assert_reset("t3_reset");
    count_until(0, 1'b0, 50, n);
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    expect_val("t3_relock_latency", LockLat);
    count_until(1, 1'b1, 100, n);
    score(n);
    check_eq("t3_retry_cnt", int'(retry_cnt), 0);

    // 4: repeated lock loss in RUN, loss counter saturates
    loss_model = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      expect_val("t4_drop_latency", 3);
      count_until(1, 1'b0, 20, n);
      score(n);
      check_eq("t4_sys_rst", int'(sys_rst), 1);
      check_eq("t4_pll_rst_on", int'(pll_rst), 1);
      loss_model = (loss_model == 255) ? 255 : loss_model + 1;
      check_eq("t4_loss_cnt", int'(loss_cnt), loss_model);
      check_eq("t4_retry_cnt", int'(retry_cnt), 0);
      expect_val("t4_pll_rst_width", RstPulse);
      count_until(0, 1'b0, 20, n);
      score(n);
      pll_locked = 1'b1;
      expect_val("t4_relock_latency", LockLat);
      count_until(1, 1'b1, 100, n);
      score(n);
    end
    check_eq("t4_loss_final", int'(loss_cnt), 255);

    // 6: reset during RUN, then during WAIT_LOCK
    pll_locked = 1'b0;
    assert_reset("t6_run");
    count_until(0, 1'b0, 50, n);
    repeat (5) tick();
    assert_reset("t6_wait");

    // 2: no lock at all -> retries then FAIL
    expect_val("t2_fall0", RstPulse);
    expect_val("t2_rise1", RstPulse + Timeout);
    expect_val("t2_fall1", 2 * RstPulse + Timeout);
    expect_val("t2_rise2", 2 * (RstPulse + Timeout));
    expect_val("t2_fall2", 3 * RstPulse + 2 * Timeout);
    prev    = 1'b1;
    fail_at = -1;
    for (int t = 1; t <= 150; t++) begin
      tick();
      if (prev !== pll_rst) score(t);
      prev = pll_rst;
      if (lock_fail === 1'b1) begin
        fail_at = t;
        break;
      end
    end
    check_eq("t2_sb_drained", sb_q.size(), 0);
    check_eq("t2_fail_at", fail_at, 3 * (RstPulse + Timeout));
    check_eq("t2_retry_cnt", int'(retry_cnt), MaxRetry);
    check_eq("t2_pll_rst", int'(pll_rst), 0);
    check_eq("t2_sys_rst", int'(sys_rst), 1);
    bad = 0;
    repeat (200) begin
      tick();
      if (lock_fail !== 1'b1 || retry_cnt !== 2'(MaxRetry) || pll_rst !== 1'b0 ||
          sys_rst !== 1'b1 || clk_ready !== 1'b0) bad++;
    end
    check_eq("t2_hold_bad_cycles", bad, 0);

    // 5: relock_req out of FAIL
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_eq("t5_lock_fail", int'(lock_fail), 0);
    check_eq("t5_retry_cnt", int'(retry_cnt), 0);
    check_eq("t5_pll_rst", int'(pll_rst), 1);
    check_eq("t5_sys_rst", int'(sys_rst), 1);
    expect_val("t5_pll_rst_width", RstPulse);
    count_until(0, 1'b0, 20, n);
    score(n);

    // relock_req coinciding with lock loss in RUN still counts the loss
    pll_locked = 1'b1;
    expect_val("t7_lock_latency", LockLat);
    count_until(1, 1'b1, 100, n);
    score(n);
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_eq("t7_loss_cnt", int'(loss_cnt), 1);
    check_eq("t7_clk_ready", int'(clk_ready), 0);
    check_eq("t7_pll_rst", int'(pll_rst), 1);
    expect_val("t7_pll_rst_width", RstPulse);
    count_until(0, 1'b0, 20, n);
    score(n);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
